// File: rtl/calc_pkg.sv
// Shared types and defaults for the two-operand calculator sequencer.
package calc_pkg;

  localparam int DEF_OP_W = 4;
  localparam logic [2*DEF_OP_W-1:0] DEF_DIV0_CODE = 8'hFF;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  // press[0]=add, [1]=sub, [2]=mul, [3]=div; lower index wins.
  function automatic op_e pick_op(input logic [3:0] press);
    if (press[0])      return OP_ADD;
    else if (press[1]) return OP_SUB;
    else if (press[2]) return OP_MUL;
    else               return OP_DIV;
  endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative engine: shift-add multiply and restoring divide, one bit per cycle over OP_W cycles.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int OP_W = DEF_OP_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  op_e                 op_i,
  input  logic [OP_W-1:0]     a_i,
  input  logic [OP_W-1:0]     b_i,
  output logic                valid_o,
  output logic [2*OP_W-1:0]   res_o
);

  localparam int RES_W = 2 * OP_W;
  localparam int CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic [OP_W-1:0]  m_q;
  logic [RES_W-1:0] acc_q;

  logic [OP_W:0]    sum;
  logic [OP_W:0]    shifted;
  logic [OP_W:0]    trial;
  logic [RES_W-1:0] step;
  logic             last;

  // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div.
  always_comb begin
    sum     = {1'b0, acc_q[RES_W-1:OP_W]} + (acc_q[0] ? {1'b0, m_q} : '0);
    shifted = {acc_q[RES_W-1:OP_W], acc_q[OP_W-1]};
    trial   = shifted - {1'b0, m_q};
    if (is_div_q) begin
      if (trial[OP_W]) step = {shifted[OP_W-1:0], acc_q[OP_W-2:0], 1'b0};
      else             step = {trial[OP_W-1:0],   acc_q[OP_W-2:0], 1'b1};
    end else begin
      step = {sum, acc_q[OP_W-1:1]};
    end
  end

  assign last    = (cnt_q == CNT_W'(OP_W - 1));
  assign valid_o = run_q && last;
  assign res_o   = step;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
    end else if (run_q) begin
      if (last) begin
        run_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_i) begin
      is_div_q <= (op_i == OP_DIV);
      m_q      <= (op_i == OP_DIV) ? b_i : a_i;
      acc_q    <= (op_i == OP_DIV) ? {{OP_W{1'b0}}, a_i} : {{OP_W{1'b0}}, b_i};
    end else if (run_q) begin
      acc_q <= step;
    end
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator controller: edge-detects op requests, arbitrates, runs add/sub/mul/div, reports status.
// Define CALC_SYNC_EN to pass all inputs through 2-flop synchronizers.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int                  OP_W      = DEF_OP_W,
  parameter logic [2*OP_W-1:0]   DIV0_CODE = DEF_DIV0_CODE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     operand_a,
  input  logic [OP_W-1:0]     operand_b,
  input  logic                op_add,
  input  logic                op_sub,
  input  logic                op_mul,
  input  logic                op_div,
  output logic [2*OP_W-1:0]   result,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int RES_W = 2 * OP_W;

  logic [OP_W-1:0] a_s;
  logic [OP_W-1:0] b_s;
  logic [3:0]      req_s;

`ifdef CALC_SYNC_EN
  logic [OP_W-1:0] a_m_q, a_s_q, b_m_q, b_s_q;
  logic [3:0]      req_m_q, req_s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_m_q   <= '0;
      a_s_q   <= '0;
      b_m_q   <= '0;
      b_s_q   <= '0;
      req_m_q <= '0;
      req_s_q <= '0;
    end else begin
      a_m_q   <= operand_a;
      a_s_q   <= a_m_q;
      b_m_q   <= operand_b;
      b_s_q   <= b_m_q;
      req_m_q <= {op_div, op_mul, op_sub, op_add};
      req_s_q <= req_m_q;
    end
  end

  assign a_s   = a_s_q;
  assign b_s   = b_s_q;
  assign req_s = req_s_q;
`else
  assign a_s   = operand_a;
  assign b_s   = operand_b;
  assign req_s = {op_div, op_mul, op_sub, op_add};
`endif

  state_e           state_q, state_d;
  op_e              op_q, op_d, sel;
  logic [OP_W-1:0]  a_q, a_d, b_q, b_d;
  logic             div0_q, div0_d;
  logic [3:0]       hist_q, press;
  logic [RES_W-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             iter_start;
  logic             iter_valid;
  logic [RES_W-1:0] iter_res;

  assign press = req_s & ~hist_q;
  assign sel   = pick_op(press);

  calc_iter_unit #(.OP_W(OP_W)) u_iter (
    .clk_i   (clk),
    .rst_i   (reset),
    .start_i (iter_start),
    .op_i    (sel),
    .a_i     (a_s),
    .b_i     (b_s),
    .valid_o (iter_valid),
    .res_o   (iter_res)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    div0_d     = div0_q;
    result_d   = result_q;
    err_d      = err_q;
    iter_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (|press) begin
          state_d    = EXEC;
          op_d       = sel;
          a_d        = a_s;
          b_d        = b_s;
          err_d      = 1'b0;
          div0_d     = (sel == OP_DIV) && (b_s == '0);
          iter_start = (sel == OP_MUL) || ((sel == OP_DIV) && (b_s != '0));
        end
      end
      EXEC: begin
        case (op_q)
          OP_ADD: begin
            result_d = RES_W'(a_q) + RES_W'(b_q);
            state_d  = DONE;
          end
          OP_SUB: begin
            result_d = RES_W'(a_q) - RES_W'(b_q);
            state_d  = DONE;
          end
          default: begin
            if (div0_q) begin
              result_d = DIV0_CODE;
              err_d    = 1'b1;
              state_d  = DONE;
            end else if (iter_valid) begin
              result_d = iter_res;
              state_d  = DONE;
            end
          end
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // History samples every cycle so a held request never retriggers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      div0_q   <= 1'b0;
      hist_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      div0_q   <= div0_d;
      hist_q   <= req_s;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign result = result_q;
  assign busy   = (state_q == EXEC);
  assign done   = (state_q == DONE);
  assign err    = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer; latencies shift by 2 cycles when CALC_SYNC_EN is defined.
module tb_calc_op_sequencer;

`ifdef CALC_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] operand_a, operand_b;
  logic       op_add, op_sub, op_mul, op_div;
  logic [7:0] result;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;

  calc_op_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .op_add    (op_add),
    .op_sub    (op_sub),
    .op_mul    (op_mul),
    .op_div    (op_div),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Raise the masked requests, wait for done (bounded), count busy cycles; lat=-1 on timeout.
  task automatic run_op(input logic [3:0] mask, input logic [3:0] a, input logic [3:0] b,
                        input bit keep, output int lat, output int bcnt);
    operand_a = a;
    operand_b = b;
    {op_div, op_mul, op_sub, op_add} = mask;
    lat  = -1;
    bcnt = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (busy) begin
        bcnt++;
        operand_a = ~a;
        operand_b = ~b;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    if (!keep) begin
      {op_div, op_mul, op_sub, op_add} = 4'b0;
      tick();
    end
  endtask

  int lat, bcnt, dcnt;
  bit pulsed;

  initial begin
    reset = 1'b1;
    operand_a = '0;
    operand_b = '0;
    {op_div, op_mul, op_sub, op_add} = 4'b0;
    tick();
    tick();
    chk("rst_result", result, 8'h00);
    chk("rst_busy",   busy,   1'b0);
    chk("rst_done",   done,   1'b0);
    chk("rst_err",    err,    1'b0);
    reset = 1'b0;
    tick();

    // Add 9+8, then keep op_add held: no retrigger.
    run_op(4'b0001, 4'd9, 4'd8, 1'b1, lat, bcnt);
    chk("add_lat",    lat,    2 + SL);
    chk("add_busy",   bcnt,   1);
    chk("add_result", result, 8'h11);
    chk("add_err",    err,    1'b0);
    tick();
    chk("add_done_pulse", done, 1'b0);
    chk("add_busy_after", busy, 1'b0);
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) dcnt++;
    end
    chk("add_hold_nodone", dcnt, 0);
    chk("add_hold_result", result, 8'h11);
    op_add = 1'b0;
    tick();

    run_op(4'b0010, 4'd3, 4'd5, 1'b0, lat, bcnt);
    chk("sub_lat",    lat,    2 + SL);
    chk("sub_result", result, 8'hFE);

    run_op(4'b0100, 4'd15, 4'd15, 1'b0, lat, bcnt);
    chk("mul_lat",    lat,    5 + SL);
    chk("mul_busy",   bcnt,   4);
    chk("mul_result", result, 8'hE1);

    run_op(4'b1000, 4'd13, 4'd4, 1'b0, lat, bcnt);
    chk("div_lat",    lat,    5 + SL);
    chk("div_result", result, 8'h13);
    chk("div_err",    err,    1'b0);

    run_op(4'b1000, 4'd7, 4'd0, 1'b1, lat, bcnt);
    chk("div0_lat",    lat,    2 + SL);
    chk("div0_busy",   bcnt,   1);
    chk("div0_result", result, 8'hFF);
    chk("div0_err",    err,    1'b1);
    op_div = 1'b0;
    tick();
    tick();
    chk("div0_err_sticky", err,    1'b1);
    chk("div0_held",       result, 8'hFF);

    run_op(4'b0001, 4'd1, 4'd2, 1'b0, lat, bcnt);
    chk("clr_result", result, 8'h03);
    chk("clr_err",    err,    1'b0);

    // mul and div together: mul wins (3*5=0F; div would give 30).
    run_op(4'b1100, 4'd3, 4'd5, 1'b0, lat, bcnt);
    chk("arb_lat",    lat,    5 + SL);
    chk("arb_result", result, 8'h0F);

    // add pulsed while mul is busy must be dropped.
    operand_a = 4'd2;
    operand_b = 4'd3;
    op_mul = 1'b1;
    pulsed = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (op_add) op_add = 1'b0;
      if (busy && !pulsed) begin
        op_add = 1'b1;
        pulsed = 1'b1;
      end
      if (done) dcnt++;
    end
    op_mul = 1'b0;
    chk("busy_pulse_seen", pulsed, 1'b1);
    chk("busy_ign_dones",  dcnt,   1);
    chk("busy_ign_result", result, 8'h06);
    tick();
    tick();

    // Reset partway through a multiply.
    operand_a = 4'd7;
    operand_b = 4'd9;
    op_mul = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rmul_result", result, 8'h00);
    chk("rmul_busy",   busy,   1'b0);
    op_mul = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) dcnt++;
    end
    chk("rmul_nodone", dcnt,   0);
    chk("rmul_hold",   result, 8'h00);

    run_op(4'b0001, 4'd7, 4'd9, 1'b0, lat, bcnt);
    chk("post_rst_lat",    lat,    2 + SL);
    chk("post_rst_result", result, 8'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
